// File: rtl/data_mem_pkg.sv
// Shared types and lane helpers for the load/store data memory.
// Helpers work on the widest (64-bit) word; callers narrow with explicit casts.
package data_mem_pkg;

  localparam int unsigned MAX_DW = 64;

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'b00,
    SIZE_HALF  = 2'b01,
    SIZE_WORD  = 2'b10,
    SIZE_DWORD = 2'b11
  } size_e;

  typedef struct packed {
    logic [MAX_DW-1:0] rdata;
    logic              fault;
    logic              is_store;
  } rsp_t;

  typedef struct packed {
    logic       we;
    size_e      size;
    logic       sgn;
    logic [2:0] off;
    logic       fault;
  } meta_t;

  function automatic logic [7:0] lane_enable(size_e size, logic [2:0] off);
    logic [7:0] be;
    be = 8'h00;
    case (size)
      SIZE_BYTE: be = 8'h01 << off;
      SIZE_HALF: be = 8'h03 << off;
      SIZE_WORD: be = 8'h0F << off;
      default:   be = 8'hFF;
    endcase
    return be;
  endfunction

  // Store data is right-aligned; copy it into every lane slot of its size.
  function automatic logic [MAX_DW-1:0] replicate(logic [MAX_DW-1:0] wdata, size_e size);
    logic [MAX_DW-1:0] r;
    r = wdata;
    case (size)
      SIZE_BYTE: r = {8{wdata[7:0]}};
      SIZE_HALF: r = {4{wdata[15:0]}};
      SIZE_WORD: r = {2{wdata[31:0]}};
      default:   r = wdata;
    endcase
    return r;
  endfunction

  function automatic logic [MAX_DW-1:0] load_extract(logic [MAX_DW-1:0] word, size_e size,
                                                     logic [2:0] off, logic sgn);
    logic [MAX_DW-1:0] sh;
    logic [MAX_DW-1:0] r;
    sh = word >> {off, 3'b000};
    r  = sh;
    case (size)
      SIZE_BYTE: r = {{56{sgn & sh[7]}}, sh[7:0]};
      SIZE_HALF: r = {{48{sgn & sh[15]}}, sh[15:0]};
      SIZE_WORD: r = {{32{sgn & sh[31]}}, sh[31:0]};
      default:   r = sh;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_mem_if.sv
// Request/response channel between the memory stage and the data memory.
interface data_mem_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_fault;
  logic                  rsp_is_store;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_is_store
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_is_store
  );
endinterface

// File: rtl/data_mem_ram.sv
// Single-port synchronous RAM, per-byte write enable, read-first.
module data_mem_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 512
) (
  input  logic                          clk,
  input  logic                          en,
  input  logic [DATA_WIDTH/8-1:0]       be,
  input  logic [$clog2(DEPTH)-1:0]      addr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  output logic [DATA_WIDTH-1:0]         rdata
);
  localparam int unsigned BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) rdata <= mem[addr];
    for (int b = 0; b < BYTES; b++) begin
      if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end
endmodule

// File: rtl/data_mem_unit.sv
// Load/store data memory: decode and check at accept, fixed-latency read pipe,
// response FIFO with credit-based request flow control.
module data_mem_unit
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned RSP_DEPTH  = RD_LATENCY + 1
) (
  input  logic       clk,
  input  logic       reset,
  data_mem_if.slave  bus
);
  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [63:0] MEM_BYTES = 64'(DEPTH) * 64'(BYTES);

  logic [ADDR_WIDTH-1:0] addr_c;
  size_e                 size_c;
  logic [2:0]            off_c;
  logic                  misalign_c;
  logic                  fault_c;
  logic                  accept_c;
  logic                  pop_c;
  logic [BYTES-1:0]      be_c;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign addr_c   = bus.req_addr;
  assign size_c   = size_e'(bus.req_size);
  assign off_c    = 3'(addr_c[OFF_W-1:0]);
  assign accept_c = bus.req_valid & bus.req_ready;

  always_comb begin
    misalign_c = 1'b0;
    case (size_c)
      SIZE_HALF:  misalign_c = addr_c[0];
      SIZE_WORD:  misalign_c = |addr_c[1:0];
      SIZE_DWORD: misalign_c = (DATA_WIDTH != 64) || (|addr_c[2:0]);
      default:    misalign_c = 1'b0;
    endcase
  end

  assign fault_c = misalign_c | (64'(addr_c) >= MEM_BYTES);
  assign be_c    = (accept_c & bus.req_we & ~fault_c) ? BYTES'(lane_enable(size_c, off_c)) : '0;

  data_mem_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .en    (accept_c),
    .be    (be_c),
    .addr  (addr_c[OFF_W +: IDX_W]),
    .wdata (DATA_WIDTH'(replicate(MAX_DW'(bus.req_wdata), size_c))),
    .rdata (ram_rdata)
  );

  // Stage 1: request attributes travel alongside the RAM read.
  logic  s1_valid;
  meta_t s1_meta;
  rsp_t  s1_rsp_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_meta  <= '0;
    end else begin
      s1_valid <= accept_c;
      if (accept_c) begin
        s1_meta <= '{we: bus.req_we, size: size_c, sgn: bus.req_signed, off: off_c, fault: fault_c};
      end
    end
  end

  always_comb begin
    s1_rsp_c = '0;
    if (s1_valid) begin
      s1_rsp_c.fault    = s1_meta.fault;
      s1_rsp_c.is_store = s1_meta.we;
      if (!s1_meta.fault && !s1_meta.we) begin
        s1_rsp_c.rdata = load_extract(MAX_DW'(ram_rdata), s1_meta.size, s1_meta.off, s1_meta.sgn);
      end
    end
  end

  logic fin_valid;
  rsp_t fin_rsp;

  if (RD_LATENCY > 1) begin : g_out_reg
    always_ff @(posedge clk) begin
      if (reset) begin
        fin_valid <= 1'b0;
        fin_rsp   <= '0;
      end else begin
        fin_valid <= s1_valid;
        fin_rsp   <= s1_rsp_c;
      end
    end
  end else begin : g_no_out_reg
    assign fin_valid = s1_valid;
    assign fin_rsp   = s1_rsp_c;
  end

  // Response FIFO; an empty FIFO passes the pipe result straight to the outputs.
  rsp_t             fifo_mem [RSP_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic [CNT_W-1:0] credit_cnt;
  logic             fifo_empty_c;
  logic             fifo_push_c;
  logic             fifo_pop_c;
  logic             head_valid_c;
  rsp_t             head_c;

  assign fifo_empty_c = (fifo_cnt == '0);
  assign head_c       = fifo_empty_c ? fin_rsp : fifo_mem[rd_ptr];
  assign head_valid_c = !fifo_empty_c || fin_valid;
  assign pop_c        = head_valid_c & bus.rsp_ready;
  assign fifo_pop_c   = pop_c & !fifo_empty_c;
  assign fifo_push_c  = fin_valid & !(pop_c & fifo_empty_c);

  function automatic logic [PTR_W-1:0] ptr_next(logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      credit_cnt <= '0;
    end else begin
      if (fifo_push_c) begin
        fifo_mem[wr_ptr] <= fin_rsp;
        wr_ptr           <= ptr_next(wr_ptr);
      end
      if (fifo_pop_c) rd_ptr <= ptr_next(rd_ptr);
      fifo_cnt   <= fifo_cnt + CNT_W'(fifo_push_c) - CNT_W'(fifo_pop_c);
      credit_cnt <= credit_cnt + CNT_W'(accept_c) - CNT_W'(pop_c);
    end
  end

  assign bus.req_ready    = !reset && ((credit_cnt < CNT_W'(RSP_DEPTH)) || pop_c);
  assign bus.rsp_valid    = head_valid_c;
  assign bus.rsp_rdata    = DATA_WIDTH'(head_c.rdata);
  assign bus.rsp_fault    = head_c.fault;
  assign bus.rsp_is_store = head_c.is_store;

  if (DATA_WIDTH < MAX_DW) begin : g_narrow
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^head_c.rdata[MAX_DW-1:DATA_WIDTH];
  end

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(fifo_push_c && !fifo_pop_c && fifo_cnt == CNT_W'(RSP_DEPTH)));

endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: byte-array reference model, in-order response checks.
module tb_data_mem_unit #(
  parameter int unsigned DW    = 32,
  parameter int unsigned LAT   = 1,
  parameter int unsigned RSPD  = LAT + 1,
  parameter int unsigned DEPTH = 512
);
  localparam int unsigned DWB        = DW / 8;
  localparam int unsigned MEM_BYTES  = DEPTH * DWB;
  localparam int unsigned INIT_BYTES = 64 * DWB;
  localparam logic [1:0]  FULL_SIZE  = (DW == 64) ? 2'd3 : 2'd2;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [63:0] wdata;
  } op_t;

  typedef struct {
    logic [63:0] rdata;
    logic        fault;
    logic        is_store;
    time         t;
    bit          chk_lat;
    int          id;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   rsp_mode;
  bit   lat_ok;
  int   next_id;
  exp_t q[$];
  logic [7:0] ref_mem [MEM_BYTES];

  data_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(32)) bus ();

  data_mem_unit #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (32),
    .RD_LATENCY (LAT),
    .RSP_DEPTH  (RSPD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic op_t mk(logic we, logic [1:0] size, logic sgn, logic [31:0] addr, logic [63:0] wdata);
    op_t o;
    o.we = we; o.size = size; o.sgn = sgn; o.addr = addr; o.wdata = wdata;
    return o;
  endfunction

  // Reference model: memory as a flat byte array, little-endian, updated in issue order.
  function automatic exp_t model(op_t op);
    exp_t        e;
    int          n;
    logic [63:0] v;
    n = 1 << op.size;
    e.rdata    = 64'd0;
    e.is_store = op.we;
    e.t        = 0;
    e.chk_lat  = 1'b0;
    e.id       = 0;
    e.fault    = (op.size == 2'd3 && DW == 32) || (op.addr % n != 0) || (op.addr >= MEM_BYTES);
    if (!e.fault) begin
      if (op.we) begin
        for (int i = 0; i < n; i++) ref_mem[op.addr + i] = op.wdata[8*i +: 8];
      end else begin
        v = 64'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[op.addr + i];
        if (op.sgn && n < int'(DWB) && v[8*n-1]) v = v | (~64'd0 << (8*n));
        if (DW == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        e.rdata = v;
      end
    end
    return e;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int  r;
    int  n;
    o.we    = 1'($urandom_range(0, 1));
    o.sgn   = 1'($urandom_range(0, 1));
    o.size  = 2'($urandom_range(0, (DW == 64) ? 3 : 2));
    if ($urandom_range(0, 15) == 0) o.size = 2'd3;
    n       = 1 << o.size;
    o.wdata = {$urandom(), $urandom()};
    r       = int'($urandom_range(0, 15));
    if (r == 0)      o.addr = 32'($urandom_range(0, INIT_BYTES - 1));
    else if (r == 1) o.addr = 32'(MEM_BYTES + $urandom_range(0, 255) * n);
    else if (r == 2) o.addr = $urandom() | 32'h8000_0000;
    else             o.addr = 32'($urandom_range(0, INIT_BYTES - 1)) & ~32'(n - 1);
    return o;
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Present one request for one cycle; on accept, update the model and queue the response.
  task automatic issue_once(op_t op, output bit acc);
    exp_t e;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = op.we;
    bus.req_size   = op.size;
    bus.req_signed = op.sgn;
    bus.req_addr   = op.addr;
    bus.req_wdata  = DW'(op.wdata);
    #4;
    acc = bus.req_ready;
    if (acc) begin
      e         = model(op);
      e.t       = $time;
      e.chk_lat = lat_ok;
      e.id      = next_id++;
      q.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic issue(op_t op);
    bit acc;
    int tries;
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 200) begin
      issue_once(op, acc);
      tries++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: request at %h not accepted in %0d cycles", op.addr, tries);
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
    end
  endtask

  // Mode 0 = always ready (drains the DUT first), 1 = never ready, 2 = random.
  task automatic set_mode(int m);
    int k;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rsp_mode      = m;
    if (m != 0) begin
      lat_ok = 1'b0;
    end else begin
      k = 0;
      while (q.size() != 0 && k < 200) begin
        @(negedge clk);
        k++;
      end
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL drain: %0d responses outstanding, expected 0", q.size());
      end
      lat_ok = 1'b1;
    end
  endtask

  task automatic do_reset(int cycles);
    @(negedge clk);
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    q.delete();
    lat_ok        = 1'b0;
    repeat (cycles - 1) @(negedge clk);
    #4;
    check("req_ready_in_reset", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #4;
    check("rsp_valid_after_reset", 64'(bus.rsp_valid), 64'd0);
    check("rsp_rdata_after_reset", 64'(bus.rsp_rdata), 64'd0);
    check("rsp_flags_after_reset", 64'({bus.rsp_fault, bus.rsp_is_store}), 64'd0);
    check("req_ready_after_reset", 64'(bus.req_ready), 64'd1);
    lat_ok = (rsp_mode == 0);
  endtask

  // Monitor: drive rsp_ready, then compare each consumed response with the queue head.
  initial begin
    exp_t        e;
    logic [63:0] got;
    bus.rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rsp_mode)
        0:       bus.rsp_ready = 1'b1;
        1:       bus.rsp_ready = 1'b0;
        default: bus.rsp_ready = 1'($urandom_range(0, 1));
      endcase
      #4;
      if (!reset && bus.rsp_valid && bus.rsp_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: got rdata %h fault %0b store %0b, expected no response",
                   bus.rsp_rdata, bus.rsp_fault, bus.rsp_is_store);
        end else begin
          e   = q.pop_front();
          got = 64'(bus.rsp_rdata);
          if (got !== e.rdata || bus.rsp_fault !== e.fault || bus.rsp_is_store !== e.is_store) begin
            errors++;
            $display("FAIL rsp%0d: got rdata %h fault %0b store %0b, expected rdata %h fault %0b store %0b",
                     e.id, got, bus.rsp_fault, bus.rsp_is_store, e.rdata, e.fault, e.is_store);
          end
          if (e.chk_lat) begin
            checks++;
            if (($time - e.t) != 64'(LAT * 10)) begin
              errors++;
              $display("FAIL latency%0d: got %0d time units, expected %0d", e.id, $time - e.t, LAT * 10);
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    bit acc;
    int n_acc;
    int stalls;
    checks         = 0;
    errors         = 0;
    next_id        = 0;
    rsp_mode       = 0;
    lat_ok         = 1'b0;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = '0;

    do_reset(3);

    // Give the low region known contents.
    for (int w = 0; w < 64; w++) issue(mk(1'b1, FULL_SIZE, 1'b0, 32'(w * DWB), {$urandom(), $urandom()}));
    set_mode(0);

    // Word store/load, then sub-word access and extension.
    issue(mk(1'b1, 2'd2, 1'b0, 32'h10, 64'hDEADBEEF));
    issue(mk(1'b0, 2'd2, 1'b0, 32'h10, 64'd0));
    issue(mk(1'b1, 2'd0, 1'b0, 32'h11, 64'hA5));
    issue(mk(1'b0, 2'd2, 1'b0, 32'h10, 64'd0));
    issue(mk(1'b0, 2'd0, 1'b1, 32'h11, 64'd0));
    issue(mk(1'b0, 2'd0, 1'b0, 32'h11, 64'd0));
    issue(mk(1'b0, 2'd1, 1'b1, 32'h12, 64'd0));

    // Misaligned and out-of-range requests.
    issue(mk(1'b0, 2'd1, 1'b0, 32'h13, 64'd0));
    issue(mk(1'b1, 2'd2, 1'b0, 32'(MEM_BYTES), 64'h12345678));
    issue(mk(1'b0, 2'd2, 1'b0, 32'h0, 64'd0));
    issue(mk(1'b0, 2'd3, 1'b0, 32'h0, 64'd0));

    // Store followed by load on the next cycle.
    issue(mk(1'b1, FULL_SIZE, 1'b0, 32'h20, 64'h0000CAFE));
    issue(mk(1'b0, FULL_SIZE, 1'b0, 32'h20, 64'd0));
    set_mode(0);

    // Backpressure: only RSPD requests may be accepted while responses are held.
    set_mode(1);
    n_acc = 0;
    for (int k = 0; k < int'(RSPD) + 4; k++) begin
      issue_once(mk(1'b0, 2'd2, 1'b0, 32'(4 * k), 64'd0), acc);
      if (acc) n_acc++;
    end
    check("accepts_under_backpressure", 64'(n_acc), 64'(RSPD));
    set_mode(0);

    // Sustained one request per cycle.
    stalls = 0;
    for (int k = 0; k < 24; k++) begin
      issue_once(mk(1'b0, 2'd2, 1'(k), 32'(4 * k), 64'd0), acc);
      if (!acc) stalls++;
    end
    check("stalls_at_full_rate", 64'(stalls), 64'd0);
    set_mode(0);

    // Reset with loads in flight; earlier stores survive.
    issue(mk(1'b1, 2'd2, 1'b0, 32'h40, 64'h5A5A1234));
    set_mode(0);
    set_mode(1);
    issue(mk(1'b0, 2'd2, 1'b0, 32'h40, 64'd0));
    issue(mk(1'b0, 2'd2, 1'b0, 32'h44, 64'd0));
    do_reset(1);
    set_mode(0);
    idle(10);
    issue(mk(1'b0, 2'd2, 1'b0, 32'h40, 64'd0));
    issue(mk(1'b0, 2'd1, 1'b1, 32'h42, 64'd0));
    set_mode(0);

    // Randomized traffic with random response backpressure.
    set_mode(2);
    for (int k = 0; k < 400; k++) begin
      issue(rand_op());
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    set_mode(0);

    // Randomized traffic with latency checks.
    for (int k = 0; k < 100; k++) issue(rand_op());
    set_mode(0);
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
Parametrised load/store data memory for the cpu core. It replaces the fixed 512x32 word-only array with byte/half/word access, sign/zero extension, alignment and range checking, and a configurable read latency. A valid/ready request channel and an in-order response channel with backpressure, buffered internally, let the pipelined core stall cleanly on the memory stage.

Parameters:
DATA_WIDTH, 32, word width in bits; 32 or 64.
DEPTH, 512, number of words; power of two.
ADDR_WIDTH, 32, byte-address width on the request port.
RD_LATENCY, 1, cycles from request accept to response valid; 1 or 2 (2 adds an output register).
RSP_DEPTH, RD_LATENCY+1, response buffer entries; at least RD_LATENCY+1.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid & req_ready
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 dword (DATA_WIDTH=64 only)
req_signed  in  1  load sign-extends when 1
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, right-aligned
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  out  DATA_WIDTH  load data, extended; 0 for stores and faults
rsp_fault  out  1  misaligned or out-of-range request
rsp_is_store  out  1  response belongs to a store

Behaviour:
- Reset values: req_ready=0 during reset, 1 on the first cycle after it; rsp_valid=0, rsp_rdata=0, rsp_fault=0, rsp_is_store=0. RAM contents are not reset.
- Little-endian lanes: the byte at offset k = addr[log2(DATA_WIDTH/8)-1:0] occupies bits [8k+7:8k]. Word index = addr >> log2(DATA_WIDTH/8).
- Alignment: byte always aligned; half requires addr[0]=0; word requires addr[1:0]=0; dword requires addr[2:0]=0. size 11 with DATA_WIDTH=32 is a fault.
- Range: a byte address >= DEPTH*DATA_WIDTH/8 is a fault.
- A faulting request writes nothing and still produces one response, with rsp_fault=1 and rdata=0.
- Store: the word and byte enables are computed at accept, and the RAM is written at that same edge. Only the enabled lanes change; store data is replicated to the lanes selected by the offset.
- Load: the RAM is read at the accept edge. Lanes are extracted and zero- or sign-extended as req_signed directs; signed is ignored for full-width loads.
- Ordering and latency:
  - Every accepted request yields exactly one response, in order.
  - With rsp_ready held high, rsp_valid rises exactly RD_LATENCY cycles after accept.
  - Full throughput is one request per cycle.
- Read after write: a load accepted the cycle after a store to the same word returns the post-store data. Single port, so there is no same-cycle conflict.
- Backpressure and credit:
  - A counter tracks in-flight plus buffered responses.
  - req_ready = !reset && (count < RSP_DEPTH), or count == RSP_DEPTH with a response popping this cycle.
  - Pipeline results enter the response FIFO; the FIFO head drives the rsp_* outputs.
  - Simultaneous push and pop leaves count unchanged.
  - The FIFO never overflows; this is asserted in simulation.
- Reset mid-operation: in-flight and buffered responses are discarded and the counter clears to 0. Stores accepted before the reset edge remain in RAM.
- Request inputs are ignored when req_valid=0 or req_ready=0.

Decomposition:
- Package data_mem_pkg:
  - size encodings: SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_DWORD
  - response struct: rdata, fault, is_store
  - functions: lane-enable generation and load extraction
- Sub-module data_mem_ram: single-port synchronous RAM with per-byte write enable, DEPTH x DATA_WIDTH, read-first.
- The response FIFO and credit logic stay in data_mem_unit.

Test Plan:
1. Defaults, rsp_ready=1: store word 0xDEADBEEF @0x10, then load word @0x10 -> after RD_LATENCY cycles, rdata=0xDEADBEEF, fault=0; the store response has is_store=1, rdata=0.
2. Byte and half access: store byte 0xA5 @0x11, then:
   - load word @0x10 -> 0xDEADA5EF
   - signed byte @0x11 -> 0xFFFFFFA5
   - unsigned byte @0x11 -> 0x000000A5
   - signed half @0x12 -> 0xFFFFDEAD
3. Faults:
   - load half @0x13 -> fault=1, rdata=0
   - store word 0x12345678 @0x800 (out of range) -> fault=1
   - a following load word @0x0 returns its prior value unchanged
4. Backpressure:
   - rsp_ready=0, back-to-back loads -> req_ready drops after RSP_DEPTH accepts
   - raise rsp_ready -> all responses arrive in order, none lost or duplicated
   - sustained one request per cycle thereafter
5. Reset with 2 loads in flight: reset held 1 cycle -> rsp_valid=0 on the next cycle and no stale responses afterwards; earlier stores are preserved.
6. Back-to-back store 0x0000CAFE @0x20 (cycle n) and load @0x20 (cycle n+1) -> rdata=0x0000CAFE. Repeat with RD_LATENCY=2 and DATA_WIDTH=64, using a dword access @0x20.
